// File: rtl/pointwise_conv_tiled.sv
// Tiled 1x1 convolution: per filter and tile, accumulate w*in over channels in a
// local buffer, then write the tile out through optional BN, ReLU and saturation.
module pointwise_conv_tiled #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 48,
    parameter int FRAC_BITS = 8,
    parameter int TILE_MAX  = 64,
    parameter int ADDR_W    = 27
) (
    input  logic              CLOCK_50MHZ,
    input  logic              RESET,
    input  logic              start,
    input  logic [15:0]       npix,
    input  logic [11:0]       cin,
    input  logic [11:0]       cout,
    input  logic              bn_en,
    input  logic              relu_en,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] bn_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);

    localparam int P_W    = $clog2(TILE_MAX + 1);
    localparam int IDX_W  = (TILE_MAX > 1) ? $clog2(TILE_MAX) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int PW     = ACC_W + DATA_W + 2;
    localparam logic [16:0] TMAX = 17'(TILE_MAX);
    localparam logic signed [PW-1:0] HALF    = PW'((PW'(1) << FRAC_BITS) >> 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_GAMMA, S_BETA, S_WGT, S_IN, S_WRITE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       rd_req_q, rd_req_d, rd_wait_q, rd_wait_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic [15:0]                npix_q, npix_d, tbase_q, tbase_d;
    logic [11:0]                cin_q, cin_d, cout_q, cout_d, f_q, f_d, c_q, c_d;
    logic                       bn_q, bn_d, relu_q, relu_d;
    logic [ADDR_W-1:0]          in_base_q, in_base_d, w_base_q, w_base_d;
    logic [ADDR_W-1:0]          bn_base_q, bn_base_d, out_base_q, out_base_d;
    logic [P_W-1:0]             p_q, p_d, tlen;
    logic signed [DATA_W-1:0]   w_q, w_d, gamma_q, gamma_d, beta_q, beta_d;
    logic signed [ACC_W-1:0]    acc_q [TILE_MAX];
    logic signed [ACC_W-1:0]    acc_base, acc_val;
    logic signed [PROD_W-1:0]   prod;
    logic [IDX_W-1:0]           acc_idx;
    logic                       acc_we, rd_fire;
    logic [16:0]                rem, next_tb;

    // Fixed-point post stage: round-half-up shift, optional BN, ReLU, saturate.
    function automatic logic [DATA_W-1:0] post_fn(input logic signed [ACC_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] g,
                                                  input logic signed [DATA_W-1:0] b,
                                                  input logic bn, input logic relu);
        logic signed [PW-1:0] t;
        t = (PW'(a) + HALF) >>> FRAC_BITS;
        if (bn)
            t = ((t * PW'(g) + HALF) >>> FRAC_BITS) + PW'(b);
        if (relu && t[PW-1])
            t = '0;
        if (t > SAT_MAX)
            t = SAT_MAX;
        else if (t < SAT_MIN)
            t = SAT_MIN;
        return t[DATA_W-1:0];
    endfunction

    always_comb begin
        rem      = {1'b0, npix_q} - {1'b0, tbase_q};
        tlen     = (rem > TMAX) ? P_W'(TILE_MAX) : P_W'(rem);
        next_tb  = {1'b0, tbase_q} + 17'(tlen);
        acc_idx  = p_q[IDX_W-1:0];
        prod     = PROD_W'(w_q) * PROD_W'($signed(rd_data));
        acc_base = (c_q == '0) ? '0 : acc_q[acc_idx];
        acc_val  = acc_base + ACC_W'(prod);
        rd_fire  = rd_wait_q && rd_valid;
    end

    always_comb begin
        state_d    = state_q;
        rd_req_d   = rd_req_q;
        rd_wait_d  = rd_wait_q;
        rd_addr_d  = rd_addr_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        npix_d     = npix_q;
        cin_d      = cin_q;
        cout_d     = cout_q;
        bn_d       = bn_q;
        relu_d     = relu_q;
        in_base_d  = in_base_q;
        w_base_d   = w_base_q;
        bn_base_d  = bn_base_q;
        out_base_d = out_base_q;
        f_d        = f_q;
        c_d        = c_q;
        tbase_d    = tbase_q;
        p_d        = p_q;
        w_d        = w_q;
        gamma_d    = gamma_q;
        beta_d     = beta_q;
        acc_we     = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                npix_d = npix;       cin_d = cin;         cout_d = cout;
                bn_d = bn_en;        relu_d = relu_en;
                in_base_d = in_base; w_base_d = w_base;
                bn_base_d = bn_base; out_base_d = out_base;
                f_d = '0; c_d = '0; tbase_d = '0; p_d = '0;
                if (npix == '0 || cin == '0 || cout == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    busy_d   = 1'b1;
                    rd_req_d = 1'b1;
                    state_d  = bn_en ? S_GAMMA : S_WGT;
                end
            end
            S_GAMMA, S_BETA, S_WGT, S_IN: begin
                if (rd_req_q && rd_gnt) begin
                    rd_req_d  = 1'b0;
                    rd_wait_d = 1'b1;
                end
                if (rd_fire) begin
                    rd_wait_d = 1'b0;
                    rd_req_d  = 1'b1;
                    case (state_q)
                        S_GAMMA: begin gamma_d = $signed(rd_data); state_d = S_BETA; end
                        S_BETA:  begin beta_d  = $signed(rd_data); state_d = S_WGT;  end
                        S_WGT: begin
                            w_d     = $signed(rd_data);
                            p_d     = '0;
                            state_d = S_IN;
                        end
                        S_IN: begin
                            acc_we = 1'b1;
                            if (p_q == tlen - P_W'(1)) begin
                                p_d = '0;
                                if (c_q == cin_q - 12'd1) begin
                                    rd_req_d = 1'b0;
                                    state_d  = S_WRITE;
                                end else begin
                                    c_d     = c_q + 12'd1;
                                    state_d = S_WGT;
                                end
                            end else begin
                                p_d = p_q + P_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // A new write is loaded as soon as the previous one is accepted.
            S_WRITE: if (!wr_en_q || wr_ready) begin
                if (p_q < tlen) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = out_base_q + ADDR_W'(f_q) * ADDR_W'(npix_q)
                              + ADDR_W'(tbase_q) + ADDR_W'(p_q);
                    wr_data_d = post_fn(acc_q[acc_idx], gamma_q, beta_q, bn_q, relu_q);
                    p_d       = p_q + P_W'(1);
                end else begin
                    wr_en_d = 1'b0;
                    p_d     = '0;
                    c_d     = '0;
                    if (next_tb >= {1'b0, npix_q}) begin
                        tbase_d = '0;
                        if (f_q == cout_q - 12'd1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            f_d      = f_q + 12'd1;
                            rd_req_d = 1'b1;
                            state_d  = bn_q ? S_GAMMA : S_WGT;
                        end
                    end else begin
                        tbase_d  = next_tb[15:0];
                        rd_req_d = 1'b1;
                        state_d  = S_WGT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Address of a freshly issued read follows the state it will complete in.
        if (rd_req_d && !rd_req_q) begin
            case (state_d)
                S_GAMMA: rd_addr_d = bn_base_d + ADDR_W'(f_d);
                S_BETA:  rd_addr_d = bn_base_d + ADDR_W'(cout_d) + ADDR_W'(f_d);
                S_WGT:   rd_addr_d = w_base_d + ADDR_W'(f_d) * ADDR_W'(cin_d) + ADDR_W'(c_d);
                S_IN:    rd_addr_d = in_base_d + ADDR_W'(c_d) * ADDR_W'(npix_d)
                                   + ADDR_W'(tbase_d) + ADDR_W'(p_d);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            rd_req_q <= 1'b0;  rd_wait_q <= 1'b0;  rd_addr_q <= '0;
            wr_en_q <= 1'b0;   wr_addr_q <= '0;    wr_data_q <= '0;
            busy_q <= 1'b0;    done_q <= 1'b0;
            npix_q <= '0;      cin_q <= '0;        cout_q <= '0;
            bn_q <= 1'b0;      relu_q <= 1'b0;
            in_base_q <= '0;   w_base_q <= '0;     bn_base_q <= '0;  out_base_q <= '0;
            f_q <= '0;         c_q <= '0;          tbase_q <= '0;    p_q <= '0;
            w_q <= '0;         gamma_q <= '0;      beta_q <= '0;
        end else begin
            state_q <= state_d;
            rd_req_q <= rd_req_d;  rd_wait_q <= rd_wait_d;  rd_addr_q <= rd_addr_d;
            wr_en_q <= wr_en_d;    wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
            busy_q <= busy_d;      done_q <= done_d;
            npix_q <= npix_d;      cin_q <= cin_d;          cout_q <= cout_d;
            bn_q <= bn_d;          relu_q <= relu_d;
            in_base_q <= in_base_d;  w_base_q <= w_base_d;
            bn_base_q <= bn_base_d;  out_base_q <= out_base_d;
            f_q <= f_d;            c_q <= c_d;              tbase_q <= tbase_d;  p_q <= p_d;
            w_q <= w_d;            gamma_q <= gamma_d;      beta_q <= beta_d;
        end
    end

    always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < TILE_MAX; i++)
                acc_q[i] <= '0;
        end else if (acc_we) begin
            acc_q[acc_idx] <= acc_val;
        end
    end

    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pointwise_conv_tiled.sv
// Randomised bench: a memory/arbiter responder with variable grant and ready delays,
// checked against loop-level expected read and write streams.
module tb_pointwise_conv_tiled;
    localparam int  DW = 16, AW = 48, FB = 4, TM = 4, ADW = 27;
    localparam int  IB = 0, WB = 1024, BB = 2048, OB = 3072;
    localparam longint HALF = 8;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] npix = '0;
    logic [11:0] cin = '0, cout = '0;
    logic bn_en = 1'b0, relu_en = 1'b0;
    logic rd_req, wr_en, busy, done;
    logic [ADW-1:0] rd_addr, wr_addr;
    logic rd_gnt = 1'b0, rd_valid = 1'b0, wr_ready = 1'b0;
    logic [DW-1:0] rd_data = '0, wr_data;

    logic [15:0] mem [0:4095];
    int  exp_rd[$];
    int  exp_wa[$];
    longint exp_wd[$];
    int  n_vec = 0, n_bad = 0, n_in = 0;
    bit  resp_en = 1'b0;
    int  gnt_dly = -1, wr_dly = -1;

    always #10 clk = ~clk;

    pointwise_conv_tiled #(.DATA_W(DW), .ACC_W(AW), .FRAC_BITS(FB), .TILE_MAX(TM), .ADDR_W(ADW)) dut (
        .CLOCK_50MHZ(clk), .RESET(rst), .start(start), .npix(npix), .cin(cin), .cout(cout),
        .bn_en(bn_en), .relu_en(relu_en),
        .in_base(27'(IB)), .w_base(27'(WB)), .bn_base(27'(BB)), .out_base(27'(OB)),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input int a);
        return longint'($signed(mem[a]));
    endfunction

    function automatic longint post(input longint acc, input longint g, input longint b,
                                    input bit bn, input bit relu);
        longint t;
        t = (acc + HALF) >>> FB;
        if (bn) t = ((t * g + HALF) >>> FB) + b;
        if (relu && t < 0) t = 0;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    task automatic build_expect(input int np, input int ci, input int co, input bit bn, input bit relu);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        if (np == 0 || ci == 0 || co == 0) return;
        for (int f = 0; f < co; f++) begin
            if (bn) begin
                exp_rd.push_back(BB + f);
                exp_rd.push_back(BB + co + f);
            end
            for (int tb = 0; tb < np; tb += TM) begin
                int tl;
                tl = (np - tb < TM) ? np - tb : TM;
                for (int c = 0; c < ci; c++) begin
                    exp_rd.push_back(WB + f * ci + c);
                    for (int p = tb; p < tb + tl; p++) exp_rd.push_back(IB + c * np + p);
                end
                for (int p = tb; p < tb + tl; p++) begin
                    longint acc;
                    acc = 0;
                    for (int c = 0; c < ci; c++) acc += sx(WB + f * ci + c) * sx(IB + c * np + p);
                    exp_wa.push_back(OB + f * np + p);
                    exp_wd.push_back(post(acc, bn ? sx(BB + f) : 0, bn ? sx(BB + co + f) : 0, bn, relu));
                end
            end
        end
    endtask

    task automatic fill(input bit big);
        for (int a = 0; a < 64; a++) begin
            mem[IB + a] = big ? 16'($urandom) : 16'(int'($urandom_range(0, 400)) - 200);
            mem[WB + a] = big ? 16'($urandom) : 16'(int'($urandom_range(0, 40)) - 20);
            mem[BB + a] = 16'(int'($urandom_range(0, 96)) - 32);
            mem[BB + 32 + a] = 16'(int'($urandom_range(0, 600)) - 300);
        end
    endtask

    // Read side of the arbiter: grant after a delay, then return data after a latency.
    initial begin : rd_resp
        int rs, cnt, lat;
        logic [ADW-1:0] held;
        rs = 0; cnt = 0; lat = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!resp_en || rst) begin rs = 0; continue; end
            rd_gnt = 1'b0; rd_valid = 1'b0;
            if (rs == 0 && rd_req) begin
                held = rd_addr;
                cnt  = (gnt_dly >= 0) ? gnt_dly : int'($urandom_range(0, 3));
                rs   = 1;
            end
            if (rs == 1) begin
                chk("rd_req_hold", rd_req, 1);
                chk("rd_addr_hold", rd_addr, held);
                if (cnt == 0) begin
                    rd_gnt = 1'b1;
                    if (exp_rd.size() == 0) chk("rd_extra", held, -1);
                    else chk("rd_addr", held, exp_rd.pop_front());
                    if (held < WB) n_in++;
                    lat = $urandom_range(0, 2);
                    rs  = 2;
                end else cnt--;
            end else if (rs == 2) begin
                chk("rd_req_low_after_gnt", rd_req, 0);
                if (lat == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = mem[held[11:0]];
                    rs = 0;
                end else lat--;
            end
        end
    end

    initial begin : wr_resp
        int ws, wcnt;
        logic [ADW-1:0] wa;
        logic [DW-1:0] wd;
        ws = 0; wcnt = 0; wa = '0; wd = '0;
        forever begin
            @(negedge clk);
            if (!resp_en || rst) begin ws = 0; continue; end
            wr_ready = 1'b0;
            if (ws == 0 && wr_en) begin
                wa = wr_addr; wd = wr_data;
                wcnt = (wr_dly >= 0) ? wr_dly : int'($urandom_range(0, 2));
                ws = 1;
            end
            if (ws == 1) begin
                chk("wr_en_hold", wr_en, 1);
                chk("wr_addr_hold", wr_addr, wa);
                chk("wr_data_hold", wr_data, wd);
                if (wcnt == 0) begin
                    wr_ready = 1'b1;
                    if (exp_wa.size() == 0) chk("wr_extra", wa, -1);
                    else begin
                        chk("wr_addr", wa, exp_wa.pop_front());
                        chk("wr_data", longint'($signed(wd)), exp_wd.pop_front());
                    end
                    ws = 0;
                end else wcnt--;
            end
        end
    end

    task automatic run_job(input int np, input int ci, input int co, input bit bn, input bit relu);
        int dcnt;
        bit zero;
        zero = (np == 0 || ci == 0 || co == 0);
        build_expect(np, ci, co, bn, relu);
        npix = 16'(np); cin = 12'(ci); cout = 12'(co); bn_en = bn; relu_en = relu;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, zero ? 0 : 1);
        // Config changes while busy must not matter.
        npix = 16'($urandom); cin = 12'($urandom); cout = 12'($urandom);
        bn_en = ~bn; relu_en = ~relu;
        dcnt = 0;
        for (int k = 0; k < 20000; k++) begin
            if (done) begin
                dcnt++;
                chk("busy_at_done", busy, 0);
                break;
            end
            @(negedge clk);
        end
        if (dcnt == 0) chk("done_timeout", 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("done_once", dcnt, 1);
        chk("reads_left", exp_rd.size(), 0);
        chk("writes_left", exp_wa.size(), 0);
    endtask

    initial begin
        bit seen_rd, seen_wr;
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);

        // Basic MAC, values scaled by 2^FB so outputs are -3,-2,-1,0.
        for (int p = 0; p < 4; p++) begin
            mem[IB + p]     = 16'((p + 1) * 16);
            mem[IB + 4 + p] = 16'((p + 5) * 16);
        end
        mem[WB] = 16'd2; mem[WB + 1] = 16'hFFFF;
        run_job(4, 2, 1, 0, 0);
        run_job(4, 2, 1, 0, 1);

        // Saturation at both rails.
        mem[IB] = 16'd30000; mem[WB] = 16'd30000;
        run_job(1, 1, 1, 0, 0);
        mem[IB] = 16'(-30000);
        run_job(1, 1, 1, 0, 0);

        // Tiling with BN, then forced slow grant and slow write ready.
        fill(0);
        run_job(6, 1, 2, 1, 0);
        gnt_dly = 5; wr_dly = 3;
        run_job(5, 2, 2, 1, 1);
        gnt_dly = -1; wr_dly = -1;

        run_job(0, 2, 2, 0, 0);
        run_job(3, 0, 1, 1, 0);

        for (int j = 0; j < 12; j++) begin
            fill($urandom_range(0, 3) == 0);
            run_job($urandom_range(1, 9), $urandom_range(1, 3), $urandom_range(1, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of input reads.
        fill(0);
        n_in = 0;
        build_expect(8, 2, 1, 0, 0);
        npix = 16'd8; cin = 12'd2; cout = 12'd1; bn_en = 1'b0; relu_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000 && n_in < 3; k++) @(negedge clk);
        chk("reached_in_reads", n_in >= 3, 1);
        resp_en = 1'b0;
        rd_gnt = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rd_req", rd_req, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        rd_valid = 1'b1; rd_data = 16'd77;
        seen_rd = 1'b0; seen_wr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (rd_req) seen_rd = 1'b1;
            if (wr_en) seen_wr = 1'b1;
        end
        chk("no_rd_after_rst", seen_rd, 0);
        chk("no_wr_after_rst", seen_wr, 0);
        chk("idle_after_rst", busy, 0);

        resp_en = 1'b1;
        fill(0);
        run_job(7, 3, 2, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pointwise_conv_tiled.md
Name: pointwise_conv_tiled

Overview:
- Parametrised pointwise (1x1) convolution engine for the SDRAM-backed CNN datapath. Successor to the fixed 10x10 / 32-bit pointwise block.
- Computes out[f][p] = post(sum_c w[f][c]*in[c][p]). Feature maps of any size are processed in tiles of up to TILE_MAX pixels.
- Optional fixed-point batch-norm scale/shift, optional ReLU, and saturation to DATA_W.
- Talks to the shared memory arbiter through a single-outstanding read port and a back-pressured write port.

Parameters:
- DATA_W, 16, width of activations, weights, gamma, beta and output (signed).
- ACC_W, 48, accumulator width (signed); must be >= 2*DATA_W+12.
- FRAC_BITS, 8, fixed-point fraction bits used by BN rounding shifts.
- TILE_MAX, 64, accumulator buffer depth (pixels per tile).
- ADDR_W, 27, memory word-address width.

Ports:
- CLOCK_50MHZ  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE only.
- npix  in  16  pixels per channel (H*W).
- cin  in  12  input channels.
- cout  in  12  filters.
- bn_en  in  1  enable BN stage.
- relu_en  in  1  enable ReLU.
- in_base / w_base / bn_base / out_base  in  ADDR_W each  region base addresses.
- rd_req  out  1  read request.
- rd_addr  out  ADDR_W  read address.
- rd_gnt  in  1  arbiter accepted the request this cycle.
- rd_valid  in  1  read data valid.
- rd_data  in  DATA_W  read data.
- wr_en  out  1  write request.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- wr_ready  in  1  write accepted this cycle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and accumulators cleared. Reset mid-operation aborts immediately; no further memory traffic, and a late rd_valid is ignored.
- Address map:
  - input = in_base + c*npix + p
  - weight = w_base + f*cin + c
  - gamma = bn_base + f
  - beta = bn_base + cout + f
  - output = out_base + f*npix + p
- Read handshake:
  - rd_req/rd_addr are held stable until rd_gnt.
  - rd_req deasserts the cycle after rd_gnt and stays low until the matching rd_valid.
  - At most one read is outstanding; rd_valid outside a wait state is ignored.
- Write handshake: wr_en/wr_addr/wr_data are held stable until wr_ready. The next write may be presented the cycle after wr_ready.
- FSM sequence: IDLE -> (bn_en ? GAMMA -> BETA) -> per tile: WGT -> IN (tile pixels) -> next channel ... -> WRITE -> next tile / next filter -> DONE -> IDLE.
- IDLE: on start, latch all config inputs and set busy=1. If npix, cin or cout is 0, go directly to DONE with no memory access.
- GAMMA/BETA: one read each per filter, latched to internal registers.
- WGT: one weight read per (filter, tile, channel). Weights are re-fetched for every tile.
- IN: reads tile pixels in ascending order.
  - On rd_valid: acc[p] <= (c==0 ? 0 : acc[p]) + w*rd_data, registered one cycle after rd_valid.
  - Tile length is min(TILE_MAX, npix - tile_base).
- WRITE: for each p ascending, wr_data is formed as:
  - t = acc >>> FRAC_BITS with round-half-up (add 2^(FRAC_BITS-1) first)
  - if bn: t = round_shift(t*gamma) + beta
  - if relu and t < 0: t = 0
  - saturate t to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
- WRITE when bn_en=0: the output is round_shift(acc) saturated (same shift).
- DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE. start held high re-triggers from IDLE on the next cycle.
- Arithmetic: the product is a full-width signed 2*DATA_W value, sign-extended to ACC_W. Accumulation wraps at ACC_W; the parameter rule prevents overflow.
- Config inputs changed while busy have no effect.

Test Plan:
- Basic MAC, FRAC_BITS=0, TILE_MAX=64, npix=4, cin=2, cout=1, bn/relu off:
  - Stimulus: in ch0=1,2,3,4; ch1=5,6,7,8; w=2,-1.
  - Response: writes -3,-2,-1,0 to out_base..out_base+3; done pulses once; exactly 10 reads.
- ReLU: same stimulus with relu_en=1 -> writes 0,0,0,0.
- Tiling, TILE_MAX=4, npix=6, cin=1, cout=2:
  - Read order per filter: weight, in[0..3], writes 0..3, weight, in[4..5], writes 4..5.
  - Filter 1 output addresses start at out_base+6.
- BN, FRAC_BITS=16, DATA_W=32, ACC_W=76:
  - Stimulus: acc=196608 (3.0), gamma=131072 (2.0), beta=5.
  - Response: output 11 (3 -> 6 -> 11).
- Saturation, DATA_W=16, FRAC_BITS=0, npix=cin=cout=1:
  - in=200, w=200 -> 32767.
  - in=-200, w=200 -> -32768.
- Handshake/reset:
  - rd_gnt delayed 5 cycles -> rd_addr stable, no duplicate read.
  - wr_ready low 3 cycles -> wr_data/wr_addr held.
  - RESET pulsed mid-IN -> all outputs 0 within the reset cycle; rd_valid afterwards causes no write.
